imem_boot_loader: RTL and testbench

//  Boot sequencer for instruction memory. Accepts a valid/ready stream of 32-bit words,

---
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams words into instruction memory from address 0, holds the core in reset,
// then releases it. Optional trailer-word checksum when LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS   = 256,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             imem_wstb,
    output logic             core_rst,
    output logic             done,
    output logic             error
);

    localparam int unsigned REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             imem_wstb_q, imem_wstb_d;
    logic             core_rst_q, core_rst_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
`endif
    logic             hs;

    assign hs = s_valid & s_ready_q;

    // Next-state and next-output logic; registered outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        rel_cnt_d    = '0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_wstb_d  = 1'b0;
        error_d      = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    error_d = 1'b0;
                    count_d = word_count;
                    index_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    if (word_count > CNT_W'(DEPTH_WORDS)) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_LOAD;
`else
                        state_d = ST_RELEASE;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (hs && (index_q < count_q)) begin
                    imem_addr_d  = 32'({index_q, 2'b00});
                    imem_wdata_d = s_data;
                    imem_wstb_d  = 1'b1;
                    index_d      = index_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = sum_q + s_data;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                else if (hs) begin
                    // Trailer word: compare against running sum of the data words.
                    if (s_data == sum_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`else
                else if (index_q == count_q) begin
                    state_d = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                if (rel_cnt_q == REL_W'(RELEASE_DELAY - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        s_ready_d  = (state_d == ST_LOAD);
`else
        s_ready_d  = (state_d == ST_LOAD) && (index_d < count_d);
`endif
        imem_we_d  = (state_d == ST_LOAD);
        core_rst_d = (state_d != ST_RUN);
        done_d     = (state_d == ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            rel_cnt_q    <= '0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            imem_wstb_q  <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            rel_cnt_q    <= rel_cnt_d;
            s_ready_q    <= s_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_wstb_q  <= imem_wstb_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign imem_wstb  = imem_wstb_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of load sessions plus reset/abort/checksum sequences.
module tb_imem_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned DLY   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready, imem_we, imem_wstb, core_rst, done, error;
    logic [31:0] imem_addr, imem_wdata;

    imem_boot_loader #(
        .DEPTH_WORDS  (DEPTH),
        .CNT_W        (16),
        .RELEASE_DELAY(DLY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_count(word_count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .imem_wstb (imem_wstb),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every write seen on the memory port.
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          last_strobe_cyc = 0;
    always @(negedge clk) begin
        if (imem_wstb === 1'b1) begin
            mon_addr.push_back(imem_addr);
            mon_data.push_back(imem_wdata);
            last_strobe_cyc = cyc;
        end
    end

    typedef struct {
        logic [15:0] count;
        int          gap;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic        exp_err;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        case (i)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return 32'h1000_0000 + 32'(i);
        endcase
    endfunction

    // Offers one word after `gap` idle cycles; returns at the negedge after the handshake.
    task automatic send_word(input logic [31:0] w, input int gap);
        bit acc = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        for (int k = 0; k < 50 && !acc; k++) begin
            if (s_ready === 1'b1) acc = 1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!acc) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_core_run(output int low_cyc);
        int k = 0;
        while (core_rst !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        low_cyc = cyc;
        check("core_rst_release", 32'(core_rst), 32'd0);
    endtask

    task automatic run_session(input vec_t v, input int idx);
        int          base;
        int          low_cyc;
        logic [31:0] sum;
        string       tag;
        base = mon_addr.size();
        tag  = $sformatf("vec%0d", idx);
        start      = 1'b1;
        word_count = v.count;
        @(negedge clk);
        start = 1'b0;
        if (v.exp_err) begin
            repeat (3) @(negedge clk);
            check({tag, "_error"},    32'(error),    32'd1);
            check({tag, "_strobes"},  32'(mon_addr.size() - base), 32'd0);
            check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
            check({tag, "_we"},       32'(imem_we),  32'd0);
            check({tag, "_s_ready"},  32'(s_ready),  32'd0);
            return;
        end
        sum = '0;
        for (int i = 0; i < int'(v.count); i++) begin
            sum = sum + word_of(v, i);
            send_word(word_of(v, i), v.gap);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, v.gap);
`endif
        wait_core_run(low_cyc);
        check({tag, "_strobes"}, 32'(mon_addr.size() - base), 32'(v.count));
        for (int i = 0; i < int'(v.count) && base + i < mon_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), mon_addr[base + i], 32'(i) * 32'd4);
            check($sformatf("%s_data%0d", tag, i), mon_data[base + i], word_of(v, i));
        end
`ifndef LOADER_CHECKSUM_EN
        if (v.count != 16'd0)
            check({tag, "_release_delay"}, 32'(low_cyc - last_strobe_cyc), 32'(DLY + 1));
`endif
        check({tag, "_done"},  32'(done),    32'd1);
        check({tag, "_error"}, 32'(error),   32'd0);
        check({tag, "_we"},    32'(imem_we), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int base;
        int low_cyc;
        vecs[0] = '{16'd3,   0, 32'h00500093, 32'h00100113, 32'h002081B3, 1'b0};
        vecs[1] = '{16'd2,   3, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b0};
        vecs[2] = '{16'd257, 0, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[3] = '{16'd1,   0, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0};
        vecs[4] = '{16'd0,   0, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[5] = '{16'd256, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 1'b0};

        rst = 1'b1; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: core held, nothing written.
        base = mon_addr.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d_core_rst", i), 32'(core_rst), 32'd1);
            check($sformatf("idle%0d_wstb", i),     32'(imem_wstb), 32'd0);
        end
        check("idle_done",    32'(done),    32'd0);
        check("idle_we",      32'(imem_we), 32'd0);
        check("idle_s_ready", 32'(s_ready), 32'd0);
        check("idle_error",   32'(error),   32'd0);
        check("idle_addr",    imem_addr,    32'd0);
        check("idle_strobes", 32'(mon_addr.size() - base), 32'd0);

        for (int i = 0; i < 6; i++) run_session(vecs[i], i);

        // Reset asserted after the 2nd of 4 words aborts the load.
        base = mon_addr.size();
        start = 1'b1; word_count = 16'd4;
        @(negedge clk);
        start = 1'b0;
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_core_rst", 32'(core_rst), 32'd1);
        check("abort_s_ready",  32'(s_ready),  32'd0);
        check("abort_we",       32'(imem_we),  32'd0);
        check("abort_done",     32'(done),     32'd0);
        check("abort_strobes",  32'(mon_addr.size() - base), 32'd2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_more",  32'(mon_addr.size() - base), 32'd2);

`ifdef LOADER_CHECKSUM_EN
        // Matching trailer releases the core; a bad trailer flags error and keeps it in reset.
        start = 1'b1; word_count = 16'd2;
        @(negedge clk);
        start = 1'b0;
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd3, 0);
        wait_core_run(low_cyc);
        check("chk_good_done",  32'(done),  32'd1);
        check("chk_good_error", 32'(error), 32'd0);
        start = 1'b1; word_count = 16'd2;
        @(negedge clk);
        start = 1'b0;
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd4, 0);
        repeat (2) @(negedge clk);
        check("chk_bad_error",    32'(error),    32'd1);
        check("chk_bad_core_rst", 32'(core_rst), 32'd1);
        check("chk_bad_done",     32'(done),     32'd0);
        check("chk_bad_s_ready",  32'(s_ready),  32'd0);
`else
        low_cyc = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
